// File: rtl/aec_expr_tx.sv
// aec_expr_tx: transmit side of the AEC ASCII expression interface.
// Buffers 5-bit tokens, streams them as ASCII with a trailing '=', then waits for the result.
`default_nettype none

module aec_expr_tx #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tok_wr,
  input  logic [4:0] i_tok_data,
  input  logic       i_start,
  input  logic       i_aec_valid,
  input  logic [6:0] i_aec_result,
  output logic [7:0] o_ascii_out,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [6:0] o_result_q
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0]        C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]        C_CNT1  = CW'(1);
  localparam logic signed [CW:0]   C_BAL1  = (CW+1)'(1);
  localparam logic [TW-1:0]        C_T1    = TW'(1);
  localparam logic [TW-1:0]        C_TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_TERM, S_WAIT} state_t;

  state_t                r_state, w_state;
  logic [4:0]            r_buf [DEPTH];
  logic [CW-1:0]         r_count, w_count;
  logic [CW-1:0]         r_rd_ptr, w_rd_ptr;
  logic signed [CW:0]    r_bal, w_bal;
  logic                  r_neg, w_neg;
  logic [TW-1:0]         r_timer, w_timer, w_tnext;
  logic [7:0]            w_ascii;
  logic                  w_ready, w_busy, w_done, w_err, w_wr_en;
  logic [6:0]            w_result_q;

  function automatic logic [7:0] enc(input logic [4:0] t);
    enc = 8'h00;
    if (t < 5'd10)      enc = 8'h30 + {3'b000, t};
    else if (t < 5'd16) enc = 8'h57 + {3'b000, t};
    else begin
      case (t)
        5'd16:   enc = 8'h28;
        5'd17:   enc = 8'h29;
        5'd18:   enc = 8'h2A;
        5'd19:   enc = 8'h2B;
        5'd20:   enc = 8'h2D;
        default: enc = 8'h00;
      endcase
    end
  endfunction

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    w_state    = r_state;
    w_count    = r_count;
    w_rd_ptr   = r_rd_ptr;
    w_bal      = r_bal;
    w_neg      = r_neg;
    w_timer    = r_timer;
    w_tnext    = r_timer + C_T1;
    w_ascii    = 8'h00;
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_wr_en    = 1'b0;
    w_result_q = o_result_q;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (r_count != '0 && r_bal == '0 && !r_neg) begin
            w_state  = S_SEND;
            w_ascii  = enc(r_buf[0]);
            w_ready  = 1'b1;
            w_busy   = 1'b1;
            w_rd_ptr = C_CNT1;
          end else begin
            w_err   = 1'b1;
            w_count = '0;
            w_bal   = '0;
            w_neg   = 1'b0;
          end
        end else if (i_tok_wr) begin
          if (r_count >= C_DEPTH || i_tok_data > 5'd20) begin
            w_err = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_count = r_count + C_CNT1;
            if (i_tok_data == 5'd16) begin
              w_bal = r_bal + C_BAL1;
            end else if (i_tok_data == 5'd17) begin
              w_bal = r_bal - C_BAL1;
              if (r_bal[CW] || r_bal == '0) w_neg = 1'b1;
            end
          end
        end
      end
      S_SEND: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (r_rd_ptr == r_count) begin
          w_ascii = 8'h3D;
          w_state = S_TERM;
        end else begin
          w_ascii  = enc(r_buf[r_rd_ptr[AW-1:0]]);
          w_rd_ptr = r_rd_ptr + C_CNT1;
        end
      end
      S_TERM: begin
        w_busy  = 1'b1;
        w_timer = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (i_aec_valid) begin
          w_done     = 1'b1;
          w_result_q = i_aec_result;
          w_state    = S_IDLE;
          w_count    = '0;
          w_bal      = '0;
          w_neg      = 1'b0;
        end else if (w_tnext == C_TLAST) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
          w_count = '0;
          w_bal   = '0;
          w_neg   = 1'b0;
        end else begin
          w_busy  = 1'b1;
          w_timer = w_tnext;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_bal       <= '0;
      r_neg       <= 1'b0;
      r_timer     <= '0;
      o_ascii_out <= '0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_result_q  <= '0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_rd_ptr    <= w_rd_ptr;
      r_bal       <= w_bal;
      r_neg       <= w_neg;
      r_timer     <= w_timer;
      o_ascii_out <= w_ascii;
      o_ready     <= w_ready;
      o_busy      <= w_busy;
      o_done      <= w_done;
      o_err       <= w_err;
      o_result_q  <= w_result_q;
    end
  end

  // Token storage carries no reset; r_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_count[AW-1:0]] <= i_tok_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_aec_expr_tx.sv
// tb_aec_expr_tx: table vectors, directed corner sequences and randomized expressions
// checked against a queue-based transaction model of aec_expr_tx.
`timescale 1ns/1ps
`default_nettype none

module tb_aec_expr_tx;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tok_wr = 1'b0;
  logic [4:0] i_tok_data = '0;
  logic       i_start = 1'b0;
  logic       i_aec_valid = 1'b0;
  logic [6:0] i_aec_result = '0;
  logic [7:0] o_ascii_out;
  logic       o_ready, o_busy, o_done, o_err;
  logic [6:0] o_result_q;

  always #5 clk = ~clk;

  aec_expr_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst),
    .i_tok_wr(i_tok_wr), .i_tok_data(i_tok_data), .i_start(i_start),
    .i_aec_valid(i_aec_valid), .i_aec_result(i_aec_result),
    .o_ascii_out(o_ascii_out), .o_ready(o_ready), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_result_q(o_result_q)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] mq[$];
  int         m_bal = 0;
  bit         m_neg = 0;
  logic [6:0] m_res = '0;
  logic [7:0] got[$];

  typedef struct {
    logic [4:0] tok;
    bit         wr_err;
    bit         ok;
    logic [7:0] ch;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_enc(input logic [4:0] t);
    int v;
    v = int'(t);
    if (v < 10) return 8'(48 + v);
    if (v < 16) return 8'(97 + v - 10);
    case (v)
      16:      return 8'h28;
      17:      return 8'h29;
      18:      return 8'h2A;
      19:      return 8'h2B;
      default: return 8'h2D;
    endcase
  endfunction

  task automatic clear_model();
    mq.delete();
    m_bal = 0;
    m_neg = 0;
  endtask

  task automatic wr_tok(input logic [4:0] t);
    bit e;
    e = (t > 5'd20) || (mq.size() >= DEPTH);
    if (!e) begin
      mq.push_back(t);
      if (t == 5'd16) m_bal++;
      else if (t == 5'd17) begin
        m_bal--;
        if (m_bal < 0) m_neg = 1;
      end
    end
    i_tok_wr = 1'b1; i_tok_data = t;
    tick();
    i_tok_wr = 1'b0; i_tok_data = '0;
    chk("wr_err", {31'd0, o_err}, {31'd0, e});
    chk("wr_idle", {o_ready, o_busy, o_done}, 0);
  endtask

  // d = WAIT cycles before aec_valid; d > TIMEOUT-2 means valid is withheld.
  task automatic run_start(input int d, input logic [6:0] res, input bit junk);
    bit         ok;
    logic [7:0] exp[$];
    ok = (mq.size() > 0) && (m_bal == 0) && !m_neg;
    foreach (mq[i]) exp.push_back(ref_enc(mq[i]));
    exp.push_back(8'h3D);
    got.delete();
    i_start = 1'b1; i_tok_wr = junk; i_tok_data = 5'($urandom_range(0, 20));
    tick();
    i_start = 1'b0; i_tok_wr = 1'b0;
    if (!ok) begin
      chk("rej_err", {31'd0, o_err}, 1);
      chk("rej_ready_busy", {o_ready, o_busy, o_done}, 0);
      clear_model();
      tick();
      chk("rej_err_pulse", {31'd0, o_err}, 0);
      return;
    end
    for (int i = 0; i < exp.size(); i++) begin
      got.push_back(o_ascii_out);
      chk("tx_ready", {31'd0, o_ready}, 1);
      chk("tx_ascii", {24'd0, o_ascii_out}, {24'd0, exp[i]});
      chk("tx_busy_flags", {o_busy, o_done, o_err}, 3'b100);
      if (junk) begin
        i_aec_valid  = 1'($urandom_range(0, 1));
        i_aec_result = 7'($urandom);
        i_start      = 1'($urandom_range(0, 1));
        i_tok_wr     = 1'($urandom_range(0, 1));
        i_tok_data   = 5'($urandom_range(0, 20));
      end
      tick();
    end
    i_aec_valid = 1'b0; i_start = 1'b0; i_tok_wr = 1'b0;
    clear_model();
    for (int j = 1; j <= TIMEOUT; j++) begin
      if (j - 1 == d && d <= TIMEOUT - 2) begin
        i_aec_valid = 1'b1; i_aec_result = res;
        tick();
        i_aec_valid = 1'b0;
        m_res = res;
        chk("done", {o_done, o_err, o_busy, o_ready}, 4'b1000);
        chk("result_q", {25'd0, o_result_q}, {25'd0, m_res});
        break;
      end
      if (j == TIMEOUT) begin
        chk("tmo_err", {o_done, o_err, o_busy, o_ready}, 4'b0100);
        chk("tmo_result_q", {25'd0, o_result_q}, {25'd0, m_res});
        break;
      end
      chk("wait_outs", {o_ascii_out, o_ready, o_done, o_err}, 0);
      chk("wait_busy", {31'd0, o_busy}, 1);
      tick();
    end
    tick();
    chk("pulse_end", {o_done, o_err, o_busy}, 0);
  endtask

  function automatic logic [4:0] rand_tok();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 5'($urandom_range(0, 15));
    if (r < 85) return 5'($urandom_range(18, 20));
    if (r < 95) return 5'($urandom_range(16, 17));
    return 5'($urandom_range(21, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    int         d;
    t1 = '{8'h28, 8'h33, 8'h2B, 8'h34, 8'h29, 8'h2A, 8'h32, 8'h3D};
    tbl = '{
      '{5'd0,  1'b0, 1'b1, 8'h30}, '{5'd1,  1'b0, 1'b1, 8'h31}, '{5'd2,  1'b0, 1'b1, 8'h32},
      '{5'd3,  1'b0, 1'b1, 8'h33}, '{5'd4,  1'b0, 1'b1, 8'h34}, '{5'd5,  1'b0, 1'b1, 8'h35},
      '{5'd6,  1'b0, 1'b1, 8'h36}, '{5'd7,  1'b0, 1'b1, 8'h37}, '{5'd8,  1'b0, 1'b1, 8'h38},
      '{5'd9,  1'b0, 1'b1, 8'h39}, '{5'd10, 1'b0, 1'b1, 8'h61}, '{5'd11, 1'b0, 1'b1, 8'h62},
      '{5'd12, 1'b0, 1'b1, 8'h63}, '{5'd13, 1'b0, 1'b1, 8'h64}, '{5'd14, 1'b0, 1'b1, 8'h65},
      '{5'd15, 1'b0, 1'b1, 8'h66}, '{5'd16, 1'b0, 1'b0, 8'h00}, '{5'd17, 1'b0, 1'b0, 8'h00},
      '{5'd18, 1'b0, 1'b1, 8'h2A}, '{5'd19, 1'b0, 1'b1, 8'h2B}, '{5'd20, 1'b0, 1'b1, 8'h2D},
      '{5'd21, 1'b1, 1'b0, 8'h00}, '{5'd31, 1'b1, 1'b0, 8'h00}
    };

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {o_ascii_out, o_ready, o_busy, o_done, o_err, o_result_q}, 0);
    rst = 1'b0;
    tick();
    chk("post_reset_outs", {o_ascii_out, o_ready, o_busy, o_done, o_err, o_result_q}, 0);

    foreach (tbl[k]) begin
      i_tok_wr = 1'b1; i_tok_data = tbl[k].tok;
      tick();
      i_tok_wr = 1'b0;
      chk("vec_wr_err", {31'd0, o_err}, {31'd0, tbl[k].wr_err});
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      if (tbl[k].ok) begin
        chk("vec_ch", {o_ready, o_ascii_out}, {1'b1, tbl[k].ch});
        tick();
        chk("vec_term", {o_ready, o_ascii_out}, {1'b1, 8'h3D});
        tick();
        i_aec_valid = 1'b1; i_aec_result = 7'(k + 40);
        tick();
        i_aec_valid = 1'b0;
        m_res = 7'(k + 40);
        chk("vec_done", {o_done, o_err}, 2'b10);
        chk("vec_res", {25'd0, o_result_q}, {25'd0, m_res});
      end else begin
        chk("vec_rej", {o_err, o_ready}, 2'b10);
      end
      tick();
    end

    // Worked example with a hand-written expected character stream
    clear_model();
    foreach (t1[i]) if (i < 7) wr_tok(5'(i == 0 ? 16 : i == 1 ? 3 : i == 2 ? 19 : i == 3 ? 4 : i == 4 ? 17 : i == 5 ? 18 : 2));
    run_start(2, 7'd14, 1'b0);
    chk("t1_len", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_ch", {24'd0, got[i]}, {24'd0, t1[i]});
    chk("t1_result", {25'd0, o_result_q}, 14);

    wr_tok(5'd12); wr_tok(5'd20); wr_tok(5'd15);
    run_start(5, 7'd77, 1'b0);

    wr_tok(5'd16); wr_tok(5'd3);
    run_start(0, 7'd1, 1'b0);
    run_start(0, 7'd1, 1'b0);
    wr_tok(5'd5);
    run_start(1, 7'd55, 1'b0);
    chk("after_rej_len", got.size(), 2);

    for (int i = 0; i < 17; i++) wr_tok(5'd1);
    run_start(3, 7'd99, 1'b0);
    chk("full_len", got.size(), 17);

    wr_tok(5'd5);
    run_start(TIMEOUT, 7'd33, 1'b0);
    wr_tok(5'd8);
    run_start(TIMEOUT - 2, 7'd21, 1'b0);

    wr_tok(5'd17); wr_tok(5'd16); wr_tok(5'd1);
    run_start(0, 7'd0, 1'b0);

    // Reset mid-SEND
    wr_tok(5'd1); wr_tok(5'd2); wr_tok(5'd3); wr_tok(5'd4);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    chk("t6_sending", {o_ready, o_ascii_out}, {1'b1, 8'h33});
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {o_ascii_out, o_ready, o_busy, o_done, o_err, o_result_q}, 0);
    tick();
    rst = 1'b0;
    clear_model();
    m_res = '0;
    tick();
    chk("t6_idle", {o_ascii_out, o_ready, o_busy, o_done, o_err}, 0);
    wr_tok(5'd7);
    run_start(4, 7'd70, 1'b0);
    chk("t6_len", got.size(), 2);
    chk("t6_ch0", {24'd0, got[0]}, 32'h37);

    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) wr_tok(rand_tok());
      d = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 + int'($urandom_range(0, 1)) * (-1)
                                        : int'($urandom_range(0, 10));
      run_start(d, 7'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
